mioc_reset_seq: RTL and testbench

- Reset sequencer inside the MIOC, directly upstream of the system, AdamNET and cartridge reset pins.
- Synchronises the external reset requests N_CVRST (game reset) and PBRST_N (computer-mode reset switch).
- Optionally debounces PBRST_N.
- Stretches each request into clean, registered, cause-dependent RST_N, CPRST_N and NETRST_N pulses with guaranteed minimum widths.

---
 rtl/mioc_reset_seq.sv | 173 +++++++++++++++++
 tb/tb_mioc_reset_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mioc_reset_seq.sv
// MIOC reset sequencer: synchronises N_CVRST / PBRST_N into cause-dependent reset pulses.
// Define MIOC_RST_DEBOUNCE_EN to add the PBRST_N debounce counter.
module mioc_reset_seq #(
  parameter int DEB_CYCLES  = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NET_EXTRA   = 16
) (
  input  logic       B_PHI,
  input  logic       RESET,
  input  logic       N_CVRST,
  input  logic       PBRST_N,
  output logic       RST_N,
  output logic       CPRST_N,
  output logic       NETRST_N,
  output logic [1:0] RST_CAUSE
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("DEB_CYCLES must be 1..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be 1..255");
  end
  if (NET_EXTRA < 0 || NET_EXTRA > 255) begin : g_bad_net
    $error("NET_EXTRA must be 0..255");
  end

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] NET_LAST  = 8'(NET_EXTRA - 1);
  localparam bit         NET_EN    = (NET_EXTRA > 0);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD,
    NETHOLD
  } state_t;

  logic [1:0] cv_s_q, cv_s_d;
  logic [1:0] pb_s_q, pb_s_d;
  logic       cv_sync, pb_sync;
  logic       cv_req, pb_req, any_req;
  logic [1:0] req;

  always_comb begin
    cv_s_d = {cv_s_q[0], N_CVRST};
    pb_s_d = {pb_s_q[0], PBRST_N};
  end

  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      cv_s_q <= 2'b11;
      pb_s_q <= 2'b11;
    end else begin
      cv_s_q <= cv_s_d;
      pb_s_q <= pb_s_d;
    end
  end

  assign cv_sync = cv_s_q[1];
  assign pb_sync = pb_s_q[1];
  assign cv_req  = ~cv_sync;

`ifdef MIOC_RST_DEBOUNCE_EN
  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES);

  logic [7:0] deb_q, deb_d;

  always_comb begin
    deb_d = deb_q;
    if (pb_sync) begin
      deb_d = '0;
    end else if (deb_q != DEB_MAX) begin
      deb_d = deb_q + 8'd1;
    end
  end

  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_d;
    end
  end

  // The current low sample counts, so acceptance tracks the incoming count.
  assign pb_req = (deb_d == DEB_MAX);
`else
  assign pb_req = ~pb_sync;
`endif

  assign req     = {pb_req, cv_req};
  assign any_req = cv_req | pb_req;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       rst_n_q, rst_n_d;
  logic       cprst_n_q, cprst_n_d;
  logic       netrst_n_q, netrst_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACTIVE;
          cause_d = req;
        end
      end
      ACTIVE: begin
        cause_d = cause_q | req;
        if (!any_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (any_req) begin
          state_d = ACTIVE;
          cause_d = cause_q | req;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (cause_q[1] && NET_EN) ? NETHOLD : IDLE;
        end
      end
      NETHOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (any_req) begin
          state_d = ACTIVE;
          cause_d = cause_q | req;
          cnt_d   = '0;
        end else if (cnt_q == NET_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase

    // Pins are registered from the next state so they switch glitch-free.
    rst_n_d    = !(state_d == ACTIVE || state_d == HOLD);
    cprst_n_d  = !((state_d == ACTIVE || state_d == HOLD) && cause_d[0]);
    netrst_n_d = !((state_d != IDLE) && cause_d[1]);
  end

  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      cause_q    <= 2'b11;
      rst_n_q    <= 1'b0;
      cprst_n_q  <= 1'b0;
      netrst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      rst_n_q    <= rst_n_d;
      cprst_n_q  <= cprst_n_d;
      netrst_n_q <= netrst_n_d;
    end
  end

  assign RST_N     = rst_n_q;
  assign CPRST_N   = cprst_n_q;
  assign NETRST_N  = netrst_n_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_mioc_reset_seq.sv
// Bench for mioc_reset_seq: table of reset scenarios with edge-accurate
// expectations fed through a scoreboard queue, plus hand-written corner cases.
module tb_mioc_reset_seq;

  localparam int H = 16;
  localparam int N = 16;
  localparam int D = 2;
`ifdef MIOC_RST_DEBOUNCE_EN
  localparam int LP = 2 + D;
`else
  localparam int LP = 3;
`endif

  logic       B_PHI;
  logic       RESET;
  logic       N_CVRST;
  logic       PBRST_N;
  logic       RST_N;
  logic       CPRST_N;
  logic       NETRST_N;
  logic [1:0] RST_CAUSE;

  mioc_reset_seq #(
    .DEB_CYCLES (D),
    .HOLD_CYCLES(H),
    .NET_EXTRA  (N)
  ) dut (
    .B_PHI    (B_PHI),
    .RESET    (RESET),
    .N_CVRST  (N_CVRST),
    .PBRST_N  (PBRST_N),
    .RST_N    (RST_N),
    .CPRST_N  (CPRST_N),
    .NETRST_N (NETRST_N),
    .RST_CAUSE(RST_CAUSE)
  );

  initial begin
    B_PHI = 1'b0;
    forever #5 B_PHI = ~B_PHI;
  end

  typedef struct packed {
    logic       rst;
    logic       cp;
    logic       net;
    logic [1:0] cause;
  } exp_t;

  typedef struct {
    string      name;
    bit         por;
    int         cv_a, cv_b, cv2_a, cv2_b;
    int         pb_a, pb_b;
    int         fall, rise, net_rise;
    bit         cp, net;
    logic [1:0] cause;
    int         span;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] prev_cause = 2'b11;
  vec_t       tbl[6];

  function automatic vec_t mk(string nm, bit por,
                              int cva, int cvb, int cv2a, int cv2b,
                              int pba, int pbb,
                              int fall, int rise, int nrise,
                              bit cp, bit net, logic [1:0] cause);
    vec_t v;
    v.name = nm; v.por = por;
    v.cv_a = cva; v.cv_b = cvb; v.cv2_a = cv2a; v.cv2_b = cv2b;
    v.pb_a = pba; v.pb_b = pbb;
    v.fall = fall; v.rise = rise; v.net_rise = nrise;
    v.cp = cp; v.net = net; v.cause = cause;
    if (fall == 0) v.span = 10;
    else v.span = ((nrise > rise) ? nrise : rise) + 3;
    return v;
  endfunction

  function automatic bit in_win(int e, int a, int b);
    return (a != 0) && (e >= a) && (e <= b);
  endfunction

  task automatic compare(string nm, int e);
    exp_t x;
    x = sb.pop_front();
    checks++;
    if ({RST_N, CPRST_N, NETRST_N, RST_CAUSE} !== x) begin
      errors++;
      $display("FAIL %s edge %0d: got rst=%b cp=%b net=%b cause=%b, want rst=%b cp=%b net=%b cause=%b",
               nm, e, RST_N, CPRST_N, NETRST_N, RST_CAUSE,
               x.rst, x.cp, x.net, x.cause);
    end
  endtask

  task automatic tick(bit rst, bit cv, bit pb, bit chk, exp_t x,
                      string nm, int e);
    @(negedge B_PHI);
    RESET   = rst;
    N_CVRST = cv;
    PBRST_N = pb;
    if (chk) sb.push_back(x);
    @(posedge B_PHI);
    #1;
    if (chk) compare(nm, e);
  endtask

  task automatic run_row(vec_t v);
    exp_t x;
    bit   lo, nlo, hit;
    if (v.por) begin
      x = '{rst: 1'b0, cp: 1'b0, net: 1'b0, cause: 2'b11};
      for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, x, {v.name, "_hold"}, i);
    end
    for (int e = 1; e <= v.span; e++) begin
      hit     = (v.fall != 0) && (e >= v.fall);
      lo      = hit && (e < v.rise);
      nlo     = hit && (e < v.net_rise) && v.net;
      x.rst   = !lo;
      x.cp    = !(lo && v.cp);
      x.net   = !nlo;
      x.cause = hit ? v.cause : prev_cause;
      tick(1'b0,
           !(in_win(e, v.cv_a, v.cv_b) || in_win(e, v.cv2_a, v.cv2_b)),
           !in_win(e, v.pb_a, v.pb_b),
           1'b1, x, v.name, e);
    end
    if (v.fall != 0) prev_cause = v.cause;
  endtask

  task automatic point(int e, int at, exp_t x, string nm, bit cv, bit pb);
    tick(1'b0, cv, pb, (e == at), x, nm, e);
  endtask

  initial begin
    exp_t x;
    RESET   = 1'b1;
    N_CVRST = 1'b1;
    PBRST_N = 1'b1;

    tbl[0] = mk("por", 1, 0, 0, 0, 0, 0, 0, 1, H, H + N, 1, 1, 2'b11);
    tbl[1] = mk("cv4", 0, 1, 4, 0, 0, 0, 0, 3, 4 + H + 3, 4 + H + 3, 1, 0, 2'b01);
`ifdef MIOC_RST_DEBOUNCE_EN
    tbl[2] = mk("pb_glitch", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01);
`else
    tbl[2] = mk("pb_glitch", 0, 0, 0, 0, 0, 1, 1, 3, 1 + H + 3, 1 + H + 3 + N, 0, 1, 2'b10);
`endif
    tbl[3] = mk("pb5", 0, 0, 0, 0, 0, 1, 5, LP, 5 + H + 3, 5 + H + 3 + N, 0, 1, 2'b10);
    tbl[4] = mk("cv1", 0, 1, 1, 0, 0, 0, 0, 3, 1 + H + 3, 1 + H + 3, 1, 0, 2'b01);
    tbl[5] = mk("retrig", 0, 1, 4, 15, 18, 0, 0, 3, 18 + H + 3, 18 + H + 3, 1, 0, 2'b01);

    for (int r = 0; r < 6; r++) run_row(tbl[r]);

    // Both requests together: every pin low, cause reports both sources.
    for (int e = 1; e <= 45; e++) begin
      x = '{rst: 1'b0, cp: 1'b0, net: 1'b0, cause: 2'b11};
      if (e >= 4 + H + 3) begin x.rst = 1'b1; x.cp = 1'b1; end
      if (e >= 4 + H + 3 + N) x.net = 1'b1;
      if (e == 6 || e == 22 || e == 23 || e == 38 || e == 39 || e == 45)
        tick(1'b0, e > 4, e > 4, 1'b1, x, "simul", e);
      else
        tick(1'b0, e > 4, e > 4, 1'b0, x, "simul", e);
    end
    prev_cause = 2'b11;

    // Game reset, then RESET fires asynchronously part-way through HOLD.
    x = '{rst: 1'b0, cp: 1'b0, net: 1'b1, cause: 2'b01};
    for (int e = 1; e <= 10; e++) point(e, 10, x, "pre_async", e > 4, 1'b1);
    #3;
    RESET = 1'b1;
    #1;
    sb.push_back('{rst: 1'b0, cp: 1'b0, net: 1'b0, cause: 2'b11});
    compare("async_rst", 10);
    run_row(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
